// File: rtl/instr_exec_reader.sv
// Read side of the instruction register stack: walks a range of locations,
// executes each opcode and presents the result on a valid/ready channel.
module instr_exec_reader #(
  parameter int OP_W   = 32,
  parameter int RES_W  = 64,
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        first_addr,
  input  logic [ADDR_W:0]          num_instr,
  output logic [ADDR_W-1:0]        read_pointer,
  input  logic [OPC_W-1:0]         iw_opc,
  input  logic signed [OP_W-1:0]   iw_op_a,
  input  logic signed [OP_W-1:0]   iw_op_b,
  output logic                     busy,
  output logic                     done,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ADDR_W-1:0]        res_addr,
  output logic [OPC_W-1:0]         res_opcode,
  output logic signed [RES_W-1:0]  res_value,
  output logic                     res_err,
  output logic [ADDR_W:0]          err_count
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, OUT, FIN} state_t;

  typedef enum logic [OPC_W-1:0] {
    OPC_ZERO, OPC_PASSA, OPC_PASSB, OPC_ADD, OPC_SUB, OPC_MULT, OPC_DIV, OPC_MOD
  } opc_t;

  state_t state, state_nxt;

  logic [ADDR_W:0]          remaining;
  logic [OPC_W-1:0]         wk_opc;
  logic signed [OP_W-1:0]   wk_a;
  logic signed [OP_W-1:0]   wk_b;
  logic [ADDR_W-1:0]        wk_addr;
  logic signed [RES_W-1:0]  a_ext;
  logic signed [RES_W-1:0]  b_ext;
  logic signed [RES_W-1:0]  alu_value;
  logic                     alu_err;
  logic                     handshake;
  logic                     last_item;

  assign handshake = res_valid & res_ready;
  assign last_item = (remaining == (ADDR_W+1)'(1));
  assign done      = (state == FIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_instr == '0) ? FIN : FETCH;
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = OUT;
      OUT:     if (handshake) state_nxt = last_item ? FIN : FETCH;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands widened first so ADD/SUB/MULT cannot overflow the result width.
  always_comb begin
    a_ext     = {{(RES_W-OP_W){wk_a[OP_W-1]}}, wk_a};
    b_ext     = {{(RES_W-OP_W){wk_b[OP_W-1]}}, wk_b};
    alu_value = '0;
    alu_err   = 1'b0;
    case (opc_t'(wk_opc))
      OPC_ZERO:  alu_value = '0;
      OPC_PASSA: alu_value = a_ext;
      OPC_PASSB: alu_value = b_ext;
      OPC_ADD:   alu_value = a_ext + b_ext;
      OPC_SUB:   alu_value = a_ext - b_ext;
      OPC_MULT:  alu_value = a_ext * b_ext;
      OPC_DIV: begin
        if (wk_b == '0) alu_err   = 1'b1;
        else            alu_value = a_ext / b_ext;
      end
      OPC_MOD: begin
        if (wk_b == '0) alu_err   = 1'b1;
        else            alu_value = a_ext % b_ext;
      end
      default:   alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_pointer <= '0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_addr     <= '0;
      res_opcode   <= '0;
      res_value    <= '0;
      res_err      <= 1'b0;
      err_count    <= '0;
      remaining    <= '0;
      wk_opc       <= '0;
      wk_a         <= '0;
      wk_b         <= '0;
      wk_addr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            err_count <= '0;
            if (num_instr != '0) begin
              read_pointer <= first_addr;
              remaining    <= num_instr;
            end
          end
        end
        FETCH: begin
          wk_opc  <= iw_opc;
          wk_a    <= iw_op_a;
          wk_b    <= iw_op_b;
          wk_addr <= read_pointer;
        end
        EXEC: begin
          res_valid  <= 1'b1;
          res_addr   <= wk_addr;
          res_opcode <= wk_opc;
          res_value  <= alu_value;
          res_err    <= alu_err;
          if (alu_err) err_count <= err_count + (ADDR_W+1)'(1);
        end
        OUT: begin
          if (handshake) begin
            res_valid <= 1'b0;
            if (!last_item) begin
              remaining    <= remaining - (ADDR_W+1)'(1);
              read_pointer <= read_pointer + ADDR_W'(1);
            end
          end
        end
        FIN:     busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
